// File: rtl/rpm_telemetry_tx.sv
// rpm_telemetry_tx
//   UART return path of the command link. Snapshots the four RPM reader
//   words. When every channel has updated since the last frame and tx_en_i
//   is high, sends one 8N1 frame on uart_tx, LSB first:
//     A5 | rpm0 hi | rpm0 lo | rpm1 hi | ... | rpm3 lo [| checksum]
//   Build option: define TELEM_CHECKSUM_EN to append B9 = sum(B1..B8) mod 256
//   (10-byte frame). Without it the frame is 9 bytes and has no adder.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line high, waiting for full update mask and tx_en_i
//   START  | start bit (0) of the current byte
//   DATA   | eight data bits, LSB first
//   STOP   | stop bit (1); then next byte's start bit or DONE
//   DONE   | one cycle: frame_sent_o pulse, busy_o low
module rpm_telemetry_tx #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD_RATE  = 115_200,
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_en_i,
  input  logic                  rpm0_ready,
  input  logic [DATA_WIDTH-1:0] rpm0_data_o,
  input  logic                  rpm1_ready,
  input  logic [DATA_WIDTH-1:0] rpm1_data_o,
  input  logic                  rpm2_ready,
  input  logic [DATA_WIDTH-1:0] rpm2_data_o,
  input  logic                  rpm3_ready,
  input  logic [DATA_WIDTH-1:0] rpm3_data_o,
  output logic                  uart_tx,
  output logic                  busy_o,
  output logic                  frame_sent_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
`ifdef TELEM_CHECKSUM_EN
  localparam int NUM_BYTES = 10;
`else
  localparam int NUM_BYTES = 9;
`endif
  localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_baud_cnt;
  logic [2:0]              r_bit_idx;
  logic [3:0]              r_byte_idx;
  logic [7:0]              r_shift;
  logic [4*DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0]   r_snap0, r_snap1, r_snap2, r_snap3;
  logic [3:0]              r_upd_mask;

  logic [3:0]              w_ready;
  logic                    w_start;
  logic                    w_bit_end;
  logic [3:0]              w_next_idx;
  logic [7:0]              w_next_byte;

  assign w_ready    = {rpm3_ready, rpm2_ready, rpm1_ready, rpm0_ready};
  assign w_start    = (r_state == S_IDLE) && (r_upd_mask == 4'hF) && tx_en_i;
  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);
  assign w_next_idx = r_byte_idx + 4'd1;

`ifdef TELEM_CHECKSUM_EN
  logic [7:0] w_cksum;
  assign w_cksum = r_buf[63:56] + r_buf[55:48] + r_buf[47:40] + r_buf[39:32]
                 + r_buf[31:24] + r_buf[23:16] + r_buf[15:8]  + r_buf[7:0];
`endif

  // Select the byte that follows the current one out of the frozen frame buffer.
  always_comb begin
    w_next_byte = HEADER;
    case (w_next_idx)
      4'd1:    w_next_byte = r_buf[63:56];
      4'd2:    w_next_byte = r_buf[55:48];
      4'd3:    w_next_byte = r_buf[47:40];
      4'd4:    w_next_byte = r_buf[39:32];
      4'd5:    w_next_byte = r_buf[31:24];
      4'd6:    w_next_byte = r_buf[23:16];
      4'd7:    w_next_byte = r_buf[15:8];
      4'd8:    w_next_byte = r_buf[7:0];
`ifdef TELEM_CHECKSUM_EN
      4'd9:    w_next_byte = w_cksum;
`endif
      default: w_next_byte = HEADER;
    endcase
  end

  // Capture reader words in any state; a ready pulse on the frame-start edge keeps its mask bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_snap0    <= '0;
      r_snap1    <= '0;
      r_snap2    <= '0;
      r_snap3    <= '0;
      r_upd_mask <= 4'h0;
    end else begin
      if (rpm0_ready) r_snap0 <= rpm0_data_o;
      if (rpm1_ready) r_snap1 <= rpm1_data_o;
      if (rpm2_ready) r_snap2 <= rpm2_data_o;
      if (rpm3_ready) r_snap3 <= rpm3_data_o;
      r_upd_mask <= (w_start ? 4'h0 : r_upd_mask) | w_ready;
    end
  end

  // Frame sequencer: bit timing, byte stepping and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_byte_idx   <= 4'd0;
      r_shift      <= 8'h00;
      r_buf        <= '0;
      uart_tx      <= 1'b1;
      busy_o       <= 1'b0;
      frame_sent_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          frame_sent_o <= 1'b0;
          uart_tx      <= 1'b1;
          if (w_start) begin
            r_buf      <= {r_snap0, r_snap1, r_snap2, r_snap3};
            r_shift    <= HEADER;
            r_byte_idx <= 4'd0;
            r_baud_cnt <= '0;
            uart_tx    <= 1'b0;
            busy_o     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            uart_tx    <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              uart_tx   <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_byte_idx == LAST_BYTE) begin
              uart_tx      <= 1'b1;
              busy_o       <= 1'b0;
              frame_sent_o <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_byte_idx <= w_next_idx;
              r_shift    <= w_next_byte;
              uart_tx    <= 1'b0;
              r_state    <= S_START;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_DONE: begin
          frame_sent_o <= 1'b0;
          uart_tx      <= 1'b1;
          busy_o       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          uart_tx      <= 1'b1;
          busy_o       <= 1'b0;
          frame_sent_o <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpm_telemetry_tx.sv
// Bench for rpm_telemetry_tx: table-driven frames decoded off the serial line,
// directed corner sequences, and a randomized phase, all shadowed by a
// cycle-level reference model of the frame timeline.
module tb_rpm_telemetry_tx;

  localparam int BAUD = 10;
`ifdef TELEM_CHECKSUM_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 9;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * BAUD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_en_i = 1'b0;
  logic [3:0]  rdy = 4'h0;
  logic [15:0] d [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic        uart_tx, busy_o, frame_sent_o;

  int n_checks = 0;
  int n_fail = 0;

  rpm_telemetry_tx #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_WIDTH(16), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rstn(rstn), .tx_en_i(tx_en_i),
    .rpm0_ready(rdy[0]), .rpm0_data_o(d[0]),
    .rpm1_ready(rdy[1]), .rpm1_data_o(d[1]),
    .rpm2_ready(rdy[2]), .rpm2_data_o(d[2]),
    .rpm3_ready(rdy[3]), .rpm3_data_o(d[3]),
    .uart_tx(uart_tx), .busy_o(busy_o), .frame_sent_o(frame_sent_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: frame timeline per clock ----------------
  logic [15:0] m_snap [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] m_buf  [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [3:0]  m_mask = 4'h0;
  bit          m_in_frame = 1'b0;
  int          m_off = 0;

  function automatic logic [7:0] mbyte(input int j);
    int s;
    if (j == 0) return 8'hA5;
    if (j <= 8) return ((j - 1) % 2 == 0) ? m_buf[(j - 1) / 2][15:8] : m_buf[(j - 1) / 2][7:0];
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(m_buf[k][15:8]) + int'(m_buf[k][7:0]);
    return 8'(s);
  endfunction

  always @(posedge clk) begin
    bit   start;
    logic e_tx, e_busy, e_sent;
    int   bitn, pos;
    logic [7:0] bv;
    if (!rstn) begin
      for (int k = 0; k < 4; k++) m_snap[k] = 16'h0;
      m_mask = 4'h0;
      m_in_frame = 1'b0;
      m_off = 0;
    end else begin
      start = !m_in_frame && (m_mask == 4'hF) && tx_en_i;
      if (start) begin
        for (int k = 0; k < 4; k++) m_buf[k] = m_snap[k];
        m_in_frame = 1'b1;
        m_off = 0;
      end else if (m_in_frame) begin
        m_off++;
        if (m_off > FRAME_CYC) m_in_frame = 1'b0;
      end
      for (int k = 0; k < 4; k++) if (rdy[k]) m_snap[k] = d[k];
      m_mask = (start ? 4'h0 : m_mask) | rdy;
    end
    if (!m_in_frame) begin
      e_tx = 1'b1; e_busy = 1'b0; e_sent = 1'b0;
    end else if (m_off == FRAME_CYC) begin
      e_tx = 1'b1; e_busy = 1'b0; e_sent = 1'b1;
    end else begin
      bitn = m_off / BAUD;
      pos  = bitn % 10;
      bv   = mbyte(bitn / 10);
      e_busy = 1'b1; e_sent = 1'b0;
      if (pos == 0) e_tx = 1'b0;
      else if (pos == 9) e_tx = 1'b1;
      else e_tx = bv[pos - 1];
    end
    #1;
    n_checks++;
    if ({uart_tx, busy_o, frame_sent_o} !== {e_tx, e_busy, e_sent}) begin
      n_fail++;
      $display("FAIL model t=%0t tx/busy/sent got=%b%b%b exp=%b%b%b",
               $time, uart_tx, busy_o, frame_sent_o, e_tx, e_busy, e_sent);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] which, input logic [15:0] v0, input logic [15:0] v1,
                       input logic [15:0] v2, input logic [15:0] v3);
    d[0] = v0; d[1] = v1; d[2] = v2; d[3] = v3;
    rdy = which;
    @(negedge clk);
    rdy = 4'h0;
  endtask

  // Called on the first negedge of the expected start bit of byte 0; returns on the DONE negedge.
  task automatic rx_frame(input string name, input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3, input logic [7:0] cks);
    logic [7:0]  exp_b [10];
    logic [15:0] v [4];
    logic [7:0]  got;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      exp_b[1 + 2 * k] = v[k][15:8];
      exp_b[2 + 2 * k] = v[k][7:0];
    end
    exp_b[9] = cks;
    chk({name, "_start"}, 8'({uart_tx, busy_o}), 8'h01);
    repeat (BAUD / 2) @(negedge clk);
    for (int j = 0; j < NBYTES; j++) begin
      chk($sformatf("%s_b%0d_startbit", name, j), 8'(uart_tx), 8'h00);
      repeat (BAUD) @(negedge clk);
      got = 8'h00;
      for (int b = 0; b < 8; b++) begin
        got[b] = uart_tx;
        repeat (BAUD) @(negedge clk);
      end
      chk($sformatf("%s_b%0d", name, j), got, exp_b[j]);
      chk($sformatf("%s_b%0d_stopbit", name, j), 8'(uart_tx), 8'h01);
      if (j != NBYTES - 1) repeat (BAUD) @(negedge clk);
    end
    repeat (BAUD / 2) @(negedge clk);
    chk({name, "_sent"}, 8'({frame_sent_o, busy_o}), 8'h02);
  endtask

  typedef struct {
    logic [15:0] d0, d1, d2, d3;
    logic [7:0]  cks;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int idle_bad;
    int waited;
    tbl[0] = '{16'h1234, 16'h00FF, 16'hABCD, 16'h8000, 8'h3D};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hF8};
    tbl[3] = '{16'h00A5, 16'h5A00, 16'h0F0F, 16'hF0F0, 8'hFD};

    // reset and 500 quiet cycles
    repeat (3) @(negedge clk);
    chk("reset_state", 8'({uart_tx, busy_o, frame_sent_o}), 8'h04);
    rstn = 1'b1;
    tx_en_i = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy_o !== 1'b0) idle_bad++;
    end
    chk("quiet_idle_bad_cycles", 8'(idle_bad), 8'h00);

    // table of frames, back to back
    for (int i = 0; i < 4; i++) begin
      pulse(4'hF, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
      @(negedge clk);
      rx_frame($sformatf("tbl%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].cks);
    end

    // updates during a frame do not disturb it and feed the next one
    pulse(4'hF, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    @(negedge clk);
    fork
      rx_frame("mid_a", 16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'h24);
      begin
        repeat (300) @(negedge clk);
        pulse(4'hF, 16'h1111, 16'h2222, 16'h0001, 16'h3333);
      end
    join
    repeat (2) @(negedge clk);
    rx_frame("mid_b", 16'h1111, 16'h2222, 16'h0001, 16'h3333, 8'hCD);

    // partial update and tx_en gating
    tx_en_i = 1'b0;
    pulse(4'b0111, 16'h4444, 16'h5555, 16'h6666, 16'h0);
    repeat (40) @(negedge clk);
    chk("partial_no_frame", 8'({uart_tx, busy_o}), 8'h02);
    pulse(4'b1000, 16'h0, 16'h0, 16'h0, 16'h7777);
    repeat (30) @(negedge clk);
    chk("en_low_no_frame", 8'({uart_tx, busy_o}), 8'h02);
    tx_en_i = 1'b1;
    @(negedge clk);
    rx_frame("en_rise", 16'h4444, 16'h5555, 16'h6666, 16'h7777, 8'hEC);

    // reset in the middle of byte 4
    pulse(4'hF, 16'h7F00, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    repeat (445) @(negedge clk);
    chk("pre_reset_low_bit", 8'({uart_tx, busy_o}), 8'h01);
    rstn = 1'b0;
    #1;
    chk("reset_truncates", 8'({uart_tx, busy_o, frame_sent_o}), 8'h04);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    pulse(4'b0111, 16'h0001, 16'h0002, 16'h0003, 16'h0);
    repeat (40) @(negedge clk);
    chk("post_reset_needs_all", 8'({uart_tx, busy_o}), 8'h02);
    pulse(4'b1000, 16'h0, 16'h0, 16'h0, 16'h0004);
    @(negedge clk);
    rx_frame("post_reset", 16'h0001, 16'h0002, 16'h0003, 16'h0004, 8'h0A);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 6000; i++) begin
      for (int k = 0; k < 4; k++) begin
        rdy[k] = ($urandom_range(0, 15) == 0);
        d[k] = 16'($urandom);
      end
      if ($urandom_range(0, 199) == 0) tx_en_i = ~tx_en_i;
      @(negedge clk);
    end
    rdy = 4'h0;
    tx_en_i = 1'b0;
    waited = 0;
    while (busy_o === 1'b1 && waited < FRAME_CYC + 20) begin
      @(negedge clk);
      waited++;
    end
    chk("final_idle", 8'(busy_o), 8'h00);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
